// File: rtl/boot_pkg.sv
// Shared constants for the boot loader: state encodings, header field
// positions and bytes-per-word for each memory target.
package boot_pkg;

    typedef logic [2:0] boot_state_t;

    localparam boot_state_t ST_IDLE    = 3'd0;
    localparam boot_state_t ST_BASE    = 3'd1;
    localparam boot_state_t ST_DATA_LO = 3'd2;
    localparam boot_state_t ST_DATA_HI = 3'd3;
    localparam boot_state_t ST_RUN     = 3'd4;
    localparam boot_state_t ST_DONE    = 3'd5;
    localparam boot_state_t ST_ERR     = 3'd6;

    localparam int TGT_BIT   = 31;
    localparam int START_BIT = 30;
    localparam int CNT_MSB   = 15;

    localparam logic [3:0] IMEM_WORD_BYTES = 4'd4;
    localparam logic [3:0] DMEM_WORD_BYTES = 4'd8;

endpackage

// File: rtl/boot_seg_counter.sv
// Tracks the current write address and remaining word count of one segment;
// the step size is captured at load so the same counter serves IMEM and DMEM.
module boot_seg_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_addr,
    input  logic [15:0] load_cnt,
    input  logic [3:0]  load_step,
    input  logic        step,
    output logic [63:0] addr,
    output logic        last
);

    logic [63:0] addr_reg;
    logic [15:0] remain_reg;
    logic [3:0]  step_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg   <= 64'd0;
            remain_reg <= 16'd0;
            step_reg   <= 4'd0;
        end else if (load) begin
            addr_reg   <= load_addr;
            remain_reg <= load_cnt;
            step_reg   <= load_step;
        end else if (step) begin
            addr_reg   <= addr_reg + {60'd0, step_reg};
            remain_reg <= remain_reg - 16'd1;
        end
    end

    assign addr = addr_reg;
    assign last = (remain_reg == 16'd1);

endmodule

// File: rtl/cpu_boot_loader.sv
// Decodes a host word stream into IMEM/DMEM write segments, then enables the
// core for a bounded run window and reports done/err.
module cpu_boot_loader
    import boot_pkg::*;
#(
    parameter int          IMEM_AW    = 9,
    parameter int          DMEM_AW    = 10,
    parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        stop,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] cycle_count
);

    boot_state_t state_reg, state_next;
    logic        tgt_reg, start_reg;
    logic [15:0] cnt_reg;
    logic [31:0] lo_reg;
    logic [31:0] count_reg;

    logic [63:0] addr_ext_reg, addr_ext_2_reg, wdata_ext_2_reg;
    logic [31:0] wdata_ext_reg;
    logic        wen_ext_reg, wen_ext_2_reg;

    logic        accept, run_active;
    logic        seg_load, seg_step, wr_imem, wr_dmem, seg_last;
    logic [63:0] seg_addr, seg_end, mem_bytes;
    logic        misaligned, overrun;

    assign s_ready = !rst && (state_reg == ST_IDLE || state_reg == ST_BASE ||
                              state_reg == ST_DATA_LO || state_reg == ST_DATA_HI);
    assign accept  = s_valid && s_ready;

    // The final strobe of a start segment overlaps the first RUN cycle; the core
    // is held off until that write has landed.
    assign run_active = (state_reg == ST_RUN) && !wen_ext_reg && !wen_ext_2_reg;

    // 64-bit span check: a 32-bit base plus at most 2^19 bytes cannot wrap.
    assign seg_end    = {32'd0, s_data} + (tgt_reg ? {45'd0, cnt_reg, 3'd0} : {46'd0, cnt_reg, 2'd0});
    assign mem_bytes  = tgt_reg ? (64'd8 << DMEM_AW) : (64'd4 << IMEM_AW);
    assign misaligned = tgt_reg ? (|s_data[2:0]) : (|s_data[1:0]);
    assign overrun    = seg_end > mem_bytes;

    boot_seg_counter u_seg (
        .clk       (clk),
        .rst       (rst),
        .load      (seg_load),
        .load_addr ({32'd0, s_data}),
        .load_cnt  (cnt_reg),
        .load_step (tgt_reg ? DMEM_WORD_BYTES : IMEM_WORD_BYTES),
        .step      (seg_step),
        .addr      (seg_addr),
        .last      (seg_last)
    );

    always_comb begin
        state_next = state_reg;
        seg_load   = 1'b0;
        seg_step   = 1'b0;
        wr_imem    = 1'b0;
        wr_dmem    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_BASE;
            end
            ST_BASE: begin
                if (accept) begin
                    if (misaligned || overrun) begin
                        state_next = ST_ERR;
                    end else if (cnt_reg == 16'd0) begin
                        state_next = start_reg ? ST_RUN : ST_IDLE;
                    end else begin
                        state_next = ST_DATA_LO;
                        seg_load   = 1'b1;
                    end
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    if (tgt_reg) begin
                        state_next = ST_DATA_HI;
                    end else begin
                        wr_imem  = 1'b1;
                        seg_step = 1'b1;
                        if (seg_last) state_next = start_reg ? ST_RUN : ST_IDLE;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    wr_dmem    = 1'b1;
                    seg_step   = 1'b1;
                    state_next = seg_last ? (start_reg ? ST_RUN : ST_IDLE) : ST_DATA_LO;
                end
            end
            ST_RUN: begin
                if (run_active && (stop || (count_reg + 32'd1 == MAX_CYCLES)))
                    state_next = ST_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            tgt_reg         <= 1'b0;
            start_reg       <= 1'b0;
            cnt_reg         <= 16'd0;
            lo_reg          <= 32'd0;
            count_reg       <= 32'd0;
            wen_ext_reg     <= 1'b0;
            wen_ext_2_reg   <= 1'b0;
            addr_ext_reg    <= 64'd0;
            wdata_ext_reg   <= 32'd0;
            addr_ext_2_reg  <= 64'd0;
            wdata_ext_2_reg <= 64'd0;
        end else begin
            state_reg     <= state_next;
            wen_ext_reg   <= wr_imem;
            wen_ext_2_reg <= wr_dmem;
            if (state_reg == ST_IDLE && accept) begin
                tgt_reg   <= s_data[TGT_BIT];
                start_reg <= s_data[START_BIT];
                cnt_reg   <= s_data[CNT_MSB:0];
            end
            if (state_reg == ST_DATA_LO && accept && tgt_reg)
                lo_reg <= s_data;
            if (wr_imem) begin
                addr_ext_reg  <= seg_addr;
                wdata_ext_reg <= s_data;
            end
            if (wr_dmem) begin
                addr_ext_2_reg  <= seg_addr;
                wdata_ext_2_reg <= {s_data, lo_reg};
            end
            if (run_active)
                count_reg <= count_reg + 32'd1;
        end
    end

    assign addr_ext    = addr_ext_reg;
    assign wen_ext     = wen_ext_reg;
    assign wdata_ext   = wdata_ext_reg;
    assign addr_ext_2  = addr_ext_2_reg;
    assign wen_ext_2   = wen_ext_2_reg;
    assign wdata_ext_2 = wdata_ext_2_reg;
    assign cpu_enable  = run_active;
    assign busy        = !(state_reg == ST_IDLE || state_reg == ST_DONE || state_reg == ST_ERR);
    assign done        = (state_reg == ST_DONE);
    assign err         = (state_reg == ST_ERR);
    assign cycle_count = count_reg;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader: a stream-level write scoreboard checked on
// every strobe, plus literal timing/status expectations per scenario.
module tb_cpu_boot_loader;

    localparam logic [31:0] MAXC = 32'd20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'd0;
    logic        stop = 1'b0;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext, cycle_count;
    logic        wen_ext, wen_ext_2, cpu_enable, busy, done, err;

    cpu_boot_loader #(.IMEM_AW(9), .DMEM_AW(10), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .stop(stop), .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int imem_seen = 0;
    int dmem_seen = 0;
    logic [95:0]  imem_q[$];
    logic [127:0] dmem_q[$];
    logic [31:0]  pay[$];
    logic [95:0]  e_i;
    logic [127:0] e_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the next expected write of its target.
    always @(negedge clk) begin
        if (!rst) begin
            if (wen_ext) begin
                imem_seen++;
                $display("imem write addr=0x%0h data=0x%08h", addr_ext, wdata_ext);
                if (imem_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL imem_unexpected: got addr 0x%0h, expected no write", addr_ext);
                end else begin
                    e_i = imem_q.pop_front();
                    check("imem_addr", addr_ext, e_i[95:32]);
                    check("imem_data", {32'd0, wdata_ext}, {32'd0, e_i[31:0]});
                end
            end
            if (wen_ext_2) begin
                dmem_seen++;
                $display("dmem write addr=0x%0h data=0x%016h", addr_ext_2, wdata_ext_2);
                if (dmem_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dmem_unexpected: got addr 0x%0h, expected no write", addr_ext_2);
                end else begin
                    e_d = dmem_q.pop_front();
                    check("dmem_addr", addr_ext_2, e_d[127:64]);
                    check("dmem_data", wdata_ext_2, e_d[63:0]);
                end
            end
            check("enable_during_strobe", {63'd0, cpu_enable && (wen_ext || wen_ext_2)}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input int gaps);
        int  n;
        logic r;
        for (int i = 0; i < gaps; i++) tick();
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        forever begin
            r = s_ready;
            tick();
            if (r) break;
            n++;
            if (n > 20) begin
                total++; bad++;
                $display("FAIL send_timeout: word 0x%08h not accepted within 20 cycles", d);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    function automatic bit seg_ok(input bit tgt, input logic [31:0] base, input int n);
        longint wb, size, b;
        wb   = tgt ? 8 : 4;
        size = tgt ? 8 * 1024 : 4 * 512;
        b    = longint'({32'd0, base});
        return (b % wb == 0) && (b + longint'(n) * wb <= size);
    endfunction

    // Expected writes of a segment, derived from the stream rules alone.
    task automatic expect_segment(input bit tgt, input logic [31:0] base, input int n);
        if (seg_ok(tgt, base, n)) begin
            for (int i = 0; i < n; i++) begin
                if (tgt) dmem_q.push_back({64'(base) + 64'(8 * i), pay[2*i+1], pay[2*i]});
                else     imem_q.push_back({64'(base) + 64'(4 * i), pay[i]});
            end
        end
    endtask

    task automatic stream_segment(input bit tgt, input bit start, input logic [31:0] base,
                                  input int n, input bit bubbles);
        send({tgt, start, 14'd0, 16'(n)}, 0);
        send(base, 0);
        if (seg_ok(tgt, base, n))
            for (int i = 0; i < pay.size(); i++)
                send(pay[i], bubbles ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_wen", {63'd0, wen_ext}, 64'd0);
        check("rst_wen2", {63'd0, wen_ext_2}, 64'd0);
        check("rst_addr", addr_ext, 64'd0);
        check("rst_wdata", {32'd0, wdata_ext}, 64'd0);
        check("rst_addr2", addr_ext_2, 64'd0);
        check("rst_wdata2", wdata_ext_2, 64'd0);
        check("rst_status", {58'd0, s_ready, cpu_enable, busy, done, err, 1'b0}, 64'd0);
        check("rst_count", {32'd0, cycle_count}, 64'd0);
        imem_q.delete();
        dmem_q.delete();
        rst = 1'b0;
        tick();
        check("post_rst_wen", {62'd0, wen_ext, wen_ext_2}, 64'd0);
        check("post_rst_ready", {63'd0, s_ready}, 64'd1);
    endtask

    task automatic queues_empty(input string name);
        check(name, 64'(imem_q.size() + dmem_q.size()), 64'd0);
    endtask

    task automatic expect_error(input bit tgt, input logic [31:0] base, input int n);
        int seen0;
        seen0 = imem_seen + dmem_seen;
        do_reset();
        pay.delete();
        stream_segment(tgt, 1'b0, base, n, 1'b0);
        check("err_flag", {63'd0, err}, 64'd1);
        check("err_ready", {62'd0, s_ready, busy}, 64'd0);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        tick(); tick(); tick();
        s_valid = 1'b0;
        check("err_sticky", {62'd0, err, s_ready}, 64'd2);
        check("err_no_strobes", 64'(imem_seen + dmem_seen - seen0), 64'd0);
    endtask

    int seen0, en_cycles, n;

    initial begin
        // 1: IMEM load then run to the cycle limit
        do_reset();
        pay = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        expect_segment(1'b0, 32'h0, 3);
        check("model_imem_w1", imem_q[1][95:32], 64'h4);
        check("model_imem_d2", {32'd0, imem_q[2][31:0]}, 64'hCCCC_0003);
        seen0 = imem_seen;
        stream_segment(1'b0, 1'b1, 32'h0, 3, 1'b0);
        check("t1_third_strobe", {62'd0, wen_ext, cpu_enable}, 64'd2);
        tick();
        check("t1_enable_rise", {63'd0, cpu_enable}, 64'd1);
        check("t1_strobes", 64'(imem_seen - seen0), 64'd3);
        en_cycles = 0;
        n = 0;
        while (!done && n < 100) begin
            if (cpu_enable) en_cycles++;
            tick();
            n++;
        end
        check("t1_done", {63'd0, done}, 64'd1);
        check("t1_enabled_cycles", 64'(en_cycles), 64'(MAXC));
        check("t1_count", {32'd0, cycle_count}, {32'd0, MAXC});
        check("t1_done_status", {61'd0, cpu_enable, s_ready, busy}, 64'd0);
        tick();
        check("t1_count_hold", {32'd0, cycle_count}, {32'd0, MAXC});
        check("t1_done_sticky", {63'd0, done}, 64'd1);
        queues_empty("t1_all_writes");

        // 2: DMEM pairing, then a second DMEM segment ending exactly at the top
        do_reset();
        pay = '{32'h1111_1111, 32'h2222_2222};
        expect_segment(1'b1, 32'h10, 1);
        check("model_dmem_d0", dmem_q[0][63:0], 64'h2222_2222_1111_1111);
        seen0 = dmem_seen;
        stream_segment(1'b1, 1'b0, 32'h10, 1, 1'b0);
        check("t2_strobe", {63'd0, wen_ext_2}, 64'd1);
        tick();
        check("t2_idle", {61'd0, cpu_enable, busy, s_ready}, 64'd1);
        check("t2_strobes", 64'(dmem_seen - seen0), 64'd1);
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back($urandom);
        expect_segment(1'b1, 32'h1FE8, 3);
        stream_segment(1'b1, 1'b0, 32'h1FE8, 3, 1'b1);
        tick();
        check("t2_top_no_err", {62'd0, err, cpu_enable}, 64'd0);
        check("t2_strobes_total", 64'(dmem_seen - seen0), 64'd4);
        queues_empty("t2_all_writes");

        // 3: malformed segments
        expect_error(1'b0, 32'h2, 1);
        expect_error(1'b0, 32'h7FC, 2);
        expect_error(1'b1, 32'h4, 1);
        do_reset();
        pay = '{32'h0123_4567, 32'h89AB_CDEF};
        expect_segment(1'b0, 32'h7F8, 2);
        seen0 = imem_seen;
        stream_segment(1'b0, 1'b0, 32'h7F8, 2, 1'b0);
        tick();
        check("t3_edge_ok", {63'd0, err}, 64'd0);
        check("t3_edge_strobes", 64'(imem_seen - seen0), 64'd2);

        // 4: backpressure and bubbles over 16 IMEM words
        do_reset();
        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back($urandom);
        expect_segment(1'b0, 32'h100, 16);
        seen0 = imem_seen;
        stream_segment(1'b0, 1'b0, 32'h100, 16, 1'b1);
        tick();
        check("t4_strobes", 64'(imem_seen - seen0), 64'd16);
        check("t4_idle", {62'd0, busy, s_ready}, 64'd1);
        queues_empty("t4_all_writes");

        // 5: early stop
        do_reset();
        pay.delete();
        stream_segment(1'b0, 1'b1, 32'h0, 0, 1'b0);
        check("t5_enable", {63'd0, cpu_enable}, 64'd1);
        check("t5_count0", {32'd0, cycle_count}, 64'd0);
        n = 0;
        while (cycle_count != 32'd5 && n < 50) begin
            tick();
            n++;
        end
        check("t5_reach5", {32'd0, cycle_count}, 64'd5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_done", {62'd0, done, cpu_enable}, 64'd2);
        check("t5_count", {32'd0, cycle_count}, 64'd6);

        // 6: reset mid-segment, then a fresh segment
        do_reset();
        pay = '{32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003};
        expect_segment(1'b0, 32'h40, 4);
        seen0 = imem_seen;
        send(32'h0000_0004, 0);
        send(32'h40, 0);
        send(pay[0], 0);
        send(pay[1], 0);
        tick();
        check("t6_before_rst", 64'(imem_seen - seen0), 64'd2);
        do_reset();
        tick();
        check("t6_no_strobe", 64'(imem_seen - seen0), 64'd2);
        pay = '{32'h6000_0000, 32'h6000_0001};
        expect_segment(1'b0, 32'h20, 2);
        stream_segment(1'b0, 1'b0, 32'h20, 2, 1'b0);
        tick();
        check("t6_fresh", 64'(imem_seen - seen0), 64'd4);
        queues_empty("t6_all_writes");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
